crash_life_ctrl: RTL and testbench
==================================

// Module: crash_life_ctrl
// PURPOSE
//  Consumes the stretched bird_crash / peas_get levels produced by the display stage and converts them into game events.
//  Owns the life counter, the white-screen flash request, post-hit invincibility and game_over.
//  life and flash are returned to the display stage.
//  Sits between the display stage and the game-flow FSM. All logic is clocked on the pixel clock.
// PARAMETERS
//  LIFE_INIT     3       lives loaded on game_start
//  LIFE_MAX      9       saturation ceiling for life (must be <=15)
//  FRAME_CYCLES  416800  clk_25mhz cycles per frame tick
//  FLASH_FRAMES  6       frames flash is held after a non-fatal hit
//  INVINC_FRAMES 60      frames of invincibility after the flash ends
// PORTS
//  clk_25mhz    in   1  pixel clock
//  rst_n        in   1  asynchronous, active-low reset
//  game_start   in   1  1-cycle pulse; (re)starts a game
//  bird_crash   in   1  level; stretched crash flag from the display stage
//  peas_get     in   1  level; stretched pea-collected flag from the display stage
//  life         out  4  current lives, to the display stage
//  flash        out  1  screen-flash request, to the display stage
//  invincible   out  1  high while crashes are ignored
//  game_over    out  1  high in OVER state
//  life_lost    out  1  1-cycle pulse per accepted crash
//  life_gained  out  1  1-cycle pulse per accepted pea
// BEHAVIOUR
//  Reset (async): state=IDLE; life=0; all other outputs 0; edge regs=0; frame_cnt=0; cyc_cnt=0.
//  All outputs are registered.
//  Edge detection:
//   - crash_rise = bird_crash & ~crash_q; pea_rise = peas_get & ~pea_q.
//   - crash_q / pea_q are updated every cycle.
//   - The level input high for ~416800 cycles therefore yields exactly one event.
//  Frame tick:
//   - cyc_cnt counts 0..FRAME_CYCLES-1; tick when cyc_cnt==FRAME_CYCLES-1.
//   - cyc_cnt and frame_cnt clear on every state entry.
//  States:
//   - IDLE: outputs 0. game_start -> life=LIFE_INIT, go PLAY.
//   - PLAY, on crash_rise: life_lost=1, life=life-1.
//       - If the new life==0: go OVER.
//       - Else: go FLASH.
//   - PLAY, on pea_rise without crash_rise:
//       - If life<LIFE_MAX: life+1, life_gained=1.
//       - If life==LIFE_MAX: no change, no pulse.
//   - FLASH: flash=1, invincible=1.
//       - crash_rise is ignored.
//       - pea_rise is handled as in PLAY.
//       - After FLASH_FRAMES ticks: go INVINC.
//   - INVINC: flash=0, invincible=1.
//       - crash_rise is ignored; pea_rise is handled as in PLAY.
//       - After INVINC_FRAMES ticks: go PLAY, invincible=0.
//   - OVER: game_over=1, flash=0, invincible=0, life=0.
//       - Events are ignored.
//       - game_start -> life=LIFE_INIT, go PLAY.
//  Simultaneous events:
//   - crash_rise and pea_rise in the same PLAY cycle: crash wins; the pea is dropped, with no life_gained.
//   - game_start in any non-IDLE state has top priority. It overrides same-cycle events.
//     It forces life=LIFE_INIT, state PLAY, and clears flash, invincible, game_over and the counters.
//  Latency:
//   - life, pulses and state change on the first clk edge that samples the input rise.
//   - They are visible in the following cycle.
//  life arithmetic is 4-bit. Underflow is impossible because crashes are accepted only in PLAY with life>=1.
//  Reset asserted mid-FLASH/INVINC aborts immediately to the IDLE reset values.
// CONFIGURATION
//  INVINC_WINDOW_EN defined:
//   - FLASH -> INVINC -> PLAY as above.
//  INVINC_WINDOW_EN undefined:
//   - INVINC state and INVINC_FRAMES are unused.
//   - FLASH goes directly to PLAY after FLASH_FRAMES ticks.
//   - invincible equals flash.
// TESTING (bench params: LIFE_INIT=3, LIFE_MAX=4, FRAME_CYCLES=10, FLASH_FRAMES=2, INVINC_FRAMES=3)
//  1. Reset, then game_start -> life=3, game_over=0, flash=0.
//  2. bird_crash high 50 cycles -> exactly one life_lost pulse; life=2.
//     flash=1 for 20 cycles, then invincible-only for 30 cycles (EN defined).
//  3. Second crash during FLASH/INVINC -> ignored, life stays 2.
//     Crash after invincible drops -> life=1.
//  4. peas_get x3 while in PLAY -> life 3,4,4: life_gained fires twice and is suppressed at LIFE_MAX.
//  5. bird_crash and peas_get rising in the same cycle at life=1 -> life=0, game_over=1, no life_gained.
//     Then game_start -> life=3, PLAY.
//  6. rst_n low mid-FLASH -> all outputs 0 asynchronously.
//     Rebuild without INVINC_WINDOW_EN: crash -> flash=invincible=1 for 20 cycles, then PLAY.

Source files
------------

// File: rtl/crash_life_ctrl.sv
// crash_life_ctrl
//
// Turns the stretched bird_crash / peas_get levels from the display stage into
// game events. Owns the life counter, the white-screen flash request, post-hit
// invincibility and game_over. All outputs are registered.
//
// Optional feature macro: INVINC_WINDOW_EN
//   defined   : after a non-fatal hit the FSM runs FLASH -> INVINC -> PLAY.
//   undefined : FLASH returns straight to PLAY; invincible mirrors flash.
//
// Parameters
//   LIFE_INIT     lives loaded on game_start
//   LIFE_MAX      saturation ceiling for life (<= 15)
//   FRAME_CYCLES  clk_25mhz cycles per frame tick
//   FLASH_FRAMES  frames flash is held after a non-fatal hit
//   INVINC_FRAMES frames of invincibility after the flash ends
//
// Ports
//   clk_25mhz    in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   game_start   in   1-cycle pulse, (re)starts a game from any state
//   bird_crash   in   level, stretched crash flag
//   peas_get     in   level, stretched pea-collected flag
//   life         out  current lives (4 bits)
//   flash        out  screen-flash request
//   invincible   out  high while crashes are ignored
//   game_over    out  high in OVER
//   life_lost    out  1-cycle pulse per accepted crash
//   life_gained  out  1-cycle pulse per accepted pea

module crash_life_ctrl #(
  parameter int unsigned LIFE_INIT     = 3,
  parameter int unsigned LIFE_MAX      = 9,
  parameter int unsigned FRAME_CYCLES  = 416800,
  parameter int unsigned FLASH_FRAMES  = 6,
  parameter int unsigned INVINC_FRAMES = 60
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       bird_crash,
  input  logic       peas_get,
  output logic [3:0] life,
  output logic       flash,
  output logic       invincible,
  output logic       game_over,
  output logic       life_lost,
  output logic       life_gained
);

  localparam int unsigned CycW     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  // Frame counter is sized for the longer of the two windows in both builds.
  localparam int unsigned FrameMax = (FLASH_FRAMES > INVINC_FRAMES) ? FLASH_FRAMES
                                                                    : INVINC_FRAMES;
  localparam int unsigned FrameW   = (FrameMax > 1) ? $clog2(FrameMax) : 1;

  localparam logic [CycW-1:0]   CycLast   = CycW'(FRAME_CYCLES - 1);
  localparam logic [FrameW-1:0] FlashLast = FrameW'(FLASH_FRAMES - 1);
`ifdef INVINC_WINDOW_EN
  localparam logic [FrameW-1:0] InvincLast = FrameW'(INVINC_FRAMES - 1);
`endif

  localparam logic [3:0] LifeInit = 4'(LIFE_INIT);
  localparam logic [3:0] LifeMax  = 4'(LIFE_MAX);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StPlay   = 3'd1;
  localparam logic [2:0] StFlash  = 3'd2;
  localparam logic [2:0] StOver   = 3'd3;
`ifdef INVINC_WINDOW_EN
  localparam logic [2:0] StInvinc = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [3:0]        life_q, life_d;
  logic              crash_q, pea_q;
  logic [CycW-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic              flash_q, flash_d;
  logic              invinc_q, invinc_d;
  logic              over_q, over_d;
  logic              lost_q, lost_d;
  logic              gained_q, gained_d;

  logic crash_rise, pea_rise, pea_ok, frame_tick, restart;

  assign crash_rise = bird_crash & ~crash_q;
  assign pea_rise   = peas_get & ~pea_q;
  assign pea_ok     = pea_rise && (life_q < LifeMax);
  assign frame_tick = (cyc_cnt_q == CycLast);

  // Next state, life and event pulses
  always_comb begin
    state_d  = state_q;
    life_d   = life_q;
    lost_d   = 1'b0;
    gained_d = 1'b0;
    if (game_start) begin
      // Overrides any same-cycle crash or pea.
      state_d = StPlay;
      life_d  = LifeInit;
    end else begin
      case (state_q)
        StIdle: begin
          life_d = 4'd0;
        end
        StPlay: begin
          if (crash_rise) begin
            // Crash wins over a same-cycle pea; life_q >= 1 here, no underflow.
            lost_d  = 1'b1;
            life_d  = life_q - 4'd1;
            state_d = (life_q == 4'd1) ? StOver : StFlash;
          end else if (pea_ok) begin
            gained_d = 1'b1;
            life_d   = life_q + 4'd1;
          end
        end
        StFlash: begin
          if (pea_ok) begin
            gained_d = 1'b1;
            life_d   = life_q + 4'd1;
          end
          if (frame_tick && (frame_cnt_q == FlashLast)) begin
`ifdef INVINC_WINDOW_EN
            state_d = StInvinc;
`else
            state_d = StPlay;
`endif
          end
        end
`ifdef INVINC_WINDOW_EN
        StInvinc: begin
          if (pea_ok) begin
            gained_d = 1'b1;
            life_d   = life_q + 4'd1;
          end
          if (frame_tick && (frame_cnt_q == InvincLast)) begin
            state_d = StPlay;
          end
        end
`endif
        StOver: begin
          life_d = 4'd0;
        end
        default: begin
          state_d = StIdle;
          life_d  = 4'd0;
        end
      endcase
    end
  end

  // Frame timing restarts on every state entry, including a restart into PLAY.
  assign restart = game_start || (state_d != state_q);

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q + 1'b1;
    frame_cnt_d = frame_cnt_q;
    if (restart) begin
      cyc_cnt_d   = '0;
      frame_cnt_d = '0;
    end else if (frame_tick) begin
      cyc_cnt_d   = '0;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Outputs are registered copies decoded from the next state.
  always_comb begin
    flash_d  = (state_d == StFlash);
    over_d   = (state_d == StOver);
`ifdef INVINC_WINDOW_EN
    invinc_d = (state_d == StFlash) || (state_d == StInvinc);
`else
    invinc_d = (state_d == StFlash);
`endif
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      life_q      <= 4'd0;
      crash_q     <= 1'b0;
      pea_q       <= 1'b0;
      cyc_cnt_q   <= '0;
      frame_cnt_q <= '0;
      flash_q     <= 1'b0;
      invinc_q    <= 1'b0;
      over_q      <= 1'b0;
      lost_q      <= 1'b0;
      gained_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      life_q      <= life_d;
      crash_q     <= bird_crash;
      pea_q       <= peas_get;
      cyc_cnt_q   <= cyc_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      flash_q     <= flash_d;
      invinc_q    <= invinc_d;
      over_q      <= over_d;
      lost_q      <= lost_d;
      gained_q    <= gained_d;
    end
  end

  assign life        = life_q;
  assign flash       = flash_q;
  assign invincible  = invinc_q;
  assign game_over   = over_q;
  assign life_lost   = lost_q;
  assign life_gained = gained_q;

endmodule

// File: tb/tb_crash_life_ctrl.sv
// Directed bench for crash_life_ctrl. Expected output snapshots are pushed to a
// scoreboard queue as stimulus is driven and popped/compared after the DUT
// clock edge. Pulse and window-length counts come from posedge monitors.
// Expectations follow INVINC_WINDOW_EN the same way the DUT build does.

module tb_crash_life_ctrl;

  logic       clk_25mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0;
  logic       bird_crash = 1'b0;
  logic       peas_get = 1'b0;
  logic [3:0] life;
  logic       flash, invincible, game_over, life_lost, life_gained;

  int checks = 0;
  int failures = 0;

  int lost_cnt = 0;
  int gained_cnt = 0;
  int flash_cnt = 0;
  int inv_cnt = 0;

`ifdef INVINC_WINDOW_EN
  localparam int InvWin = 50;
`else
  localparam int InvWin = 20;
`endif

  typedef struct {
    string      tag;
    logic [3:0] life;
    logic       flash;
    logic       inv;
    logic       over;
    logic       lost;
    logic       gained;
  } exp_t;

  exp_t sb[$];

  crash_life_ctrl #(
    .LIFE_INIT    (3),
    .LIFE_MAX     (4),
    .FRAME_CYCLES (10),
    .FLASH_FRAMES (2),
    .INVINC_FRAMES(3)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .game_start (game_start),
    .bird_crash (bird_crash),
    .peas_get   (peas_get),
    .life       (life),
    .flash      (flash),
    .invincible (invincible),
    .game_over  (game_over),
    .life_lost  (life_lost),
    .life_gained(life_gained)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  always @(posedge clk_25mhz) begin
    if (life_lost === 1'b1)   lost_cnt   <= lost_cnt + 1;
    if (life_gained === 1'b1) gained_cnt <= gained_cnt + 1;
    if (flash === 1'b1)       flash_cnt  <= flash_cnt + 1;
    if (invincible === 1'b1)  inv_cnt    <= inv_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] l, input logic f, input logic inv,
                      input logic ov, input logic lo, input logic ga);
    exp_t e;
    e.tag = tag; e.life = l; e.flash = f; e.inv = inv;
    e.over = ov; e.lost = lo; e.gained = ga;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty: got 0 entries want 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".life"},        life,        e.life);
      cmp({e.tag, ".flash"},       flash,       e.flash);
      cmp({e.tag, ".invincible"},  invincible,  e.inv);
      cmp({e.tag, ".game_over"},   game_over,   e.over);
      cmp({e.tag, ".life_lost"},   life_lost,   e.lost);
      cmp({e.tag, ".life_gained"}, life_gained, e.gained);
    end
  endtask

  // One-cycle crash pulse from PLAY; returns at the negedge after the hit edge.
  task automatic crash_pulse(input string tag, input logic [3:0] new_life);
    bird_crash = 1'b1;
    push(tag, new_life, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    bird_crash = 1'b0;
    check_pop();
  endtask

  task automatic start_game(input string tag);
    game_start = 1'b1;
    push(tag, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    game_start = 1'b0;
    check_pop();
  endtask

  initial begin
    int lost0, flash0, inv0, gained0;
    logic [3:0] pea_life [3];
    logic       pea_gain [3];
    pea_life[0] = 4'd3; pea_life[1] = 4'd4; pea_life[2] = 4'd4;
    pea_gain[0] = 1'b1; pea_gain[1] = 1'b1; pea_gain[2] = 1'b0;

    // Reset state
    tick(3);
    push("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pop();
    rst_n = 1'b1;
    tick(2);

    // Game start
    start_game("start");

    // Long crash level: one hit, re-rises inside the window are ignored
    lost0 = lost_cnt; flash0 = flash_cnt; inv0 = inv_cnt;
    for (int i = 0; i < 50; i++) begin
`ifdef INVINC_WINDOW_EN
      bird_crash = !((i == 10) || (i == 35));
`else
      bird_crash = (i != 10);
`endif
      if (i == 0) push("hit1", 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1);
      if (i == 0) check_pop();
    end
    bird_crash = 1'b0;
    tick(10);
    push("hit1_after", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pop();
    cmp("hit1_lost_pulses", lost_cnt - lost0, 1);
    cmp("hit1_flash_cycles", flash_cnt - flash0, 20);
    cmp("hit1_invinc_cycles", inv_cnt - inv0, InvWin);

    // Crash in PLAY after the window closed
    crash_pulse("hit2", 4'd1);
    tick(60);
    push("hit2_after", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pop();

    // Simultaneous crash and pea at life 1: crash wins, game over
    gained0 = gained_cnt;
    bird_crash = 1'b1;
    peas_get = 1'b1;
    push("fatal", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    bird_crash = 1'b0;
    peas_get = 1'b0;
    check_pop();
    tick(1);
    // Pea in OVER is ignored
    peas_get = 1'b1;
    push("over_pea", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    peas_get = 1'b0;
    check_pop();
    cmp("fatal_no_gain", gained_cnt - gained0, 0);
    tick(1);
    start_game("restart");

    // Peas from life 2: 3, 4, then saturate at LIFE_MAX
    crash_pulse("hit3", 4'd2);
    tick(60);
    gained0 = gained_cnt;
    for (int k = 0; k < 3; k++) begin
      peas_get = 1'b1;
      push($sformatf("pea%0d", k), pea_life[k], 1'b0, 1'b0, 1'b0, 1'b0, pea_gain[k]);
      tick(1);
      peas_get = 1'b0;
      check_pop();
      tick(1);
    end
    cmp("pea_gain_pulses", gained_cnt - gained0, 2);

    // game_start during FLASH beats a same-cycle crash
    crash_pulse("hit4", 4'd3);
    tick(3);
    game_start = 1'b1;
    bird_crash = 1'b1;
    push("start_in_flash", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    game_start = 1'b0;
    bird_crash = 1'b0;
    check_pop();
    tick(30);
    push("start_in_flash_after", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pop();

    // Asynchronous reset mid-FLASH
    crash_pulse("hit5", 4'd2);
    tick(5);
    #5 rst_n = 1'b0;
    #1;
    push("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pop();
    tick(1);
    rst_n = 1'b1;
    tick(3);
    push("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
